// File: rtl/backlight_pkg.sv
// Shared constants, FSM state type and luma helper for the zone backlight statistics block.
package backlight_pkg;

    localparam int H_ACT     = 1920;
    localparam int ZONES     = 8;
    localparam int ZONE_W    = H_ACT / ZONES;
    localparam int SUM_W     = 26;
    localparam int AVG_SHIFT = 18;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } zstate_t;

    function automatic logic [7:0] max3(input logic [23:0] p);
        logic [7:0] m;
        m = (p[23:16] > p[15:8]) ? p[23:16] : p[15:8];
        return (m > p[7:0]) ? m : p[7:0];
    endfunction

endpackage

// File: rtl/zone_acc.sv
// One zone's brightness accumulator: running max, plus a luma sum blended into the
// result when ZONE_AVG_EN is defined.
module zone_acc
    import backlight_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       upd,
    input  logic [7:0] luma,
    output logic [7:0] val
);

    logic [7:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_q <= '0;
        else if (clr)
            max_q <= '0;
        else if (upd && (luma > max_q))
            max_q <= luma;
    end

`ifdef ZONE_AVG_EN
    logic [SUM_W-1:0] sum_q;
    logic [8:0]       blend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum_q <= '0;
        else if (clr)
            sum_q <= '0;
        else if (upd)
            sum_q <= sum_q + SUM_W'(luma);
    end

    // Rounded midpoint of peak and mean; 9 bits keep the carry.
    assign blend = {1'b0, max_q} + {1'b0, sum_q[SUM_W-1:AVG_SHIFT]} + 9'd1;
    assign val   = blend[8:1];
`else
    assign val = max_q;
`endif

endmodule

// File: rtl/zone_luma_stats.sv
// Per-zone max(R,G,B) statistics for a vertical-strip backlight; results are snapshotted
// at each frame boundary and streamed out one zone per valid/ready handshake.
module zone_luma_stats #(
    parameter int H_ACT  = backlight_pkg::H_ACT,
    parameter int ZONES  = backlight_pkg::ZONES,
    parameter int ZONE_W = backlight_pkg::ZONE_W
) (
    input  logic                     iODCK,
    input  logic                     reset_n,
    input  logic                     iDE,
    input  logic                     iVSYNC,
    input  logic [23:0]              iQE,
    input  logic                     iZONE_READY,
    output logic                     oZONE_VALID,
    output logic [$clog2(ZONES)-1:0] oZONE_IDX,
    output logic [7:0]               oZONE_VAL,
    output logic                     oDROP
);
    import backlight_pkg::*;

    localparam int XW = $clog2(H_ACT);
    localparam int SW = $clog2(ZONE_W);
    localparam int IW = $clog2(ZONES);

    logic [XW-1:0] x_q;
    logic [SW-1:0] sub_q;
    logic [IW-1:0] zone_q;
    logic          past_q;
    logic          at_end;

    assign at_end = (x_q == XW'(H_ACT - 1));

    // past_q marks pixels beyond the active width once x has saturated.
    always_ff @(posedge iODCK or negedge reset_n) begin
        if (!reset_n) begin
            x_q    <= '0;
            sub_q  <= '0;
            zone_q <= '0;
            past_q <= 1'b0;
        end else if (!iDE) begin
            x_q    <= '0;
            sub_q  <= '0;
            zone_q <= '0;
            past_q <= 1'b0;
        end else if (at_end) begin
            past_q <= 1'b1;
        end else begin
            x_q <= x_q + 1'b1;
            if (sub_q == SW'(ZONE_W - 1)) begin
                sub_q  <= '0;
                zone_q <= zone_q + 1'b1;
            end else begin
                sub_q <= sub_q + 1'b1;
            end
        end
    end

    logic [7:0]    luma_q;
    logic          pix_vld_q;
    logic [IW-1:0] pix_zone_q;

    always_ff @(posedge iODCK or negedge reset_n) begin
        if (!reset_n) begin
            luma_q     <= '0;
            pix_vld_q  <= 1'b0;
            pix_zone_q <= '0;
        end else begin
            luma_q     <= max3(iQE);
            pix_vld_q  <= iDE && !past_q;
            pix_zone_q <= zone_q;
        end
    end

    // Two-cycle delay from the sampled edge lets the last pixel drain into the accumulators.
    logic       vs_q;
    logic [1:0] snap_pipe;
    logic       snap;

    always_ff @(posedge iODCK or negedge reset_n) begin
        if (!reset_n) begin
            vs_q      <= 1'b0;
            snap_pipe <= '0;
        end else begin
            vs_q      <= iVSYNC;
            snap_pipe <= {snap_pipe[0], iVSYNC && !vs_q};
        end
    end

    assign snap = snap_pipe[1];

    logic [ZONES-1:0][7:0] zone_val;

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        zone_acc u_acc (
            .clk   (iODCK),
            .rst_n (reset_n),
            .clr   (snap),
            .upd   (pix_vld_q && (pix_zone_q == IW'(z))),
            .luma  (luma_q),
            .val   (zone_val[z])
        );
    end

    zstate_t               state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  load;
    logic [ZONES-1:0][7:0] shadow_q;
    logic                  drop_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap) begin
                    state_d = SEND;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (iZONE_READY) begin
                    if (idx_q == IW'(ZONES - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iODCK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load)
                shadow_q <= zone_val;
            // A boundary mid-transfer loses the new frame; the old one keeps draining.
            drop_q <= snap && (state_q == SEND);
        end
    end

    assign oZONE_VALID = (state_q == SEND);
    assign oZONE_IDX   = idx_q;
    assign oZONE_VAL   = oZONE_VALID ? shadow_q[idx_q] : 8'h00;
    assign oDROP       = drop_q;

endmodule
